mem_port_arbiter: RTL

//  Shares one external memory port between three core requesters: icache read, dcache read, dcache write.

---
 rtl/mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one external memory port shared by icache reads, dcache
// reads and dcache writes. Round-robin grant, a single outstanding
// transaction, registered outputs and an optional watchdog abort.
module mem_port_arbiter #(
  parameter logic [2:0]  ICACHE_BITS = 3'd3,
  parameter int unsigned TIMEOUT     = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        icache_rqst_i,
  input  logic [63:0] icache_addr_i,
  output logic        icache_done_o,
  output logic [63:0] icache_data_o,
  input  logic        dcache_r_rqst_i,
  input  logic [63:0] dcache_r_addr_i,
  input  logic [2:0]  dcache_r_bits_i,
  output logic        dcache_r_done_o,
  output logic [63:0] dcache_r_data_o,
  input  logic        dcache_w_rqst_i,
  input  logic [63:0] dcache_w_addr_i,
  input  logic [2:0]  dcache_w_bits_i,
  input  logic [63:0] dcache_w_data_i,
  output logic        dcache_w_done_o,
  output logic        err_o,
  output logic        mem_rqst_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [2:0]  mem_bits_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_done_i,
  input  logic [63:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Requester indices: 0 = icache, 1 = dcache read, 2 = dcache write.
  localparam logic [1:0]  REQ_IC = 2'd0;
  localparam logic [1:0]  REQ_DR = 2'd1;
  localparam logic [31:0] TIMER_LAST = (TIMEOUT == 32'd0) ? 32'd0 : 32'(TIMEOUT - 32'd1);
  localparam logic        WDOG_EN    = (TIMEOUT != 32'd0) ? 1'b1 : 1'b0;

  // Round robin: search starts just after the last winner, order 0,1,2.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] first, second, third;
    case (last)
      2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
    if (req[first]) begin
      rr_pick = first;
    end else if (req[second]) begin
      rr_pick = second;
    end else begin
      rr_pick = third;
    end
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  rr_last_q, rr_last_d;
  logic [1:0]  grant_q, grant_d;
  logic [31:0] timer_q, timer_d;
  logic        mem_rqst_q, mem_rqst_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [2:0]  mem_bits_q, mem_bits_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  done_q, done_d;
  logic        err_q, err_d;
  logic [63:0] icache_data_q, icache_data_d;
  logic [63:0] dcache_r_data_q, dcache_r_data_d;
  logic [2:0]  req_s;
  logic [1:0]  win_s;

  assign req_s = {dcache_w_rqst_i, dcache_r_rqst_i, icache_rqst_i};
  assign win_s = rr_pick(rr_last_q, req_s);

  // Next-state and output logic for the IDLE -> BUSY -> RESP cycle.
  always_comb begin
    state_d         = state_q;
    rr_last_d       = rr_last_q;
    grant_d         = grant_q;
    timer_d         = timer_q;
    mem_rqst_d      = mem_rqst_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_bits_d      = mem_bits_q;
    mem_wdata_d     = mem_wdata_q;
    done_d          = 3'b000;
    err_d           = 1'b0;
    icache_data_d   = icache_data_q;
    dcache_r_data_d = dcache_r_data_q;

    case (state_q)
      IDLE: begin
        if (req_s != 3'b000) begin
          state_d    = BUSY;
          rr_last_d  = win_s;
          grant_d    = win_s;
          timer_d    = 32'd0;
          mem_rqst_d = 1'b1;
          case (win_s)
            REQ_IC: begin
              mem_we_d    = 1'b0;
              mem_addr_d  = icache_addr_i;
              mem_bits_d  = ICACHE_BITS;
              mem_wdata_d = 64'd0;
            end
            REQ_DR: begin
              mem_we_d    = 1'b0;
              mem_addr_d  = dcache_r_addr_i;
              mem_bits_d  = dcache_r_bits_i;
              mem_wdata_d = 64'd0;
            end
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = dcache_w_addr_i;
              mem_bits_d  = dcache_w_bits_i;
              mem_wdata_d = dcache_w_data_i;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        if (mem_done_i || (WDOG_EN && (timer_q == TIMER_LAST))) begin
          // Completion or watchdog abort: release the port and pulse done.
          state_d     = RESP;
          mem_rqst_d  = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 64'd0;
          mem_bits_d  = 3'd0;
          mem_wdata_d = 64'd0;
          err_d       = ~mem_done_i;
          case (grant_q)
            REQ_IC:  done_d = 3'b001;
            REQ_DR:  done_d = 3'b010;
            default: done_d = 3'b100;
          endcase
          if (mem_done_i && (grant_q == REQ_IC)) begin
            icache_data_d = mem_rdata_i;
          end else if (mem_done_i && (grant_q == REQ_DR)) begin
            dcache_r_data_d = mem_rdata_i;
          end else begin
            icache_data_d   = 64'd0;
            dcache_r_data_d = 64'd0;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      RESP: begin
        state_d         = IDLE;
        icache_data_d   = 64'd0;
        dcache_r_data_d = 64'd0;
      end

      default: begin
        state_d         = IDLE;
        mem_rqst_d      = 1'b0;
        mem_we_d        = 1'b0;
        mem_addr_d      = 64'd0;
        mem_bits_d      = 3'd0;
        mem_wdata_d     = 64'd0;
        icache_data_d   = 64'd0;
        dcache_r_data_d = 64'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      rr_last_q       <= 2'd2;
      grant_q         <= 2'd0;
      timer_q         <= 32'd0;
      mem_rqst_q      <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 64'd0;
      mem_bits_q      <= 3'd0;
      mem_wdata_q     <= 64'd0;
      done_q          <= 3'b000;
      err_q           <= 1'b0;
      icache_data_q   <= 64'd0;
      dcache_r_data_q <= 64'd0;
    end else begin
      state_q         <= state_d;
      rr_last_q       <= rr_last_d;
      grant_q         <= grant_d;
      timer_q         <= timer_d;
      mem_rqst_q      <= mem_rqst_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_bits_q      <= mem_bits_d;
      mem_wdata_q     <= mem_wdata_d;
      done_q          <= done_d;
      err_q           <= err_d;
      icache_data_q   <= icache_data_d;
      dcache_r_data_q <= dcache_r_data_d;
    end
  end

  assign icache_done_o   = done_q[0];
  assign dcache_r_done_o = done_q[1];
  assign dcache_w_done_o = done_q[2];
  assign icache_data_o   = icache_data_q;
  assign dcache_r_data_o = dcache_r_data_q;
  assign err_o           = err_q;
  assign mem_rqst_o      = mem_rqst_q;
  assign mem_we_o        = mem_we_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_bits_o      = mem_bits_q;
  assign mem_wdata_o     = mem_wdata_q;

endmodule
